// File: rtl/free_list.sv
// Circular free list of physical register tags feeding the rename map table.
// Ports: clock/reset, per-lane alloc_req/alloc_pr/alloc_ok, per-lane
// free_en/free_pr, BPRecoverEN, free_count, sticky overflow_err.
module free_list #(
  parameter int ARCH_COUNT = 32,
  parameter int PHYS_REGS  = 64,
  parameter int N          = 3
) (
  input  logic                                  clock,
  input  logic                                  reset,
  input  logic [N-1:0]                          alloc_req,
  output logic [N*((PHYS_REGS<=2)?1:$clog2(PHYS_REGS))-1:0] alloc_pr,
  output logic                                  alloc_ok,
  input  logic [N-1:0]                          free_en,
  input  logic [N*((PHYS_REGS<=2)?1:$clog2(PHYS_REGS))-1:0] free_pr,
  input  logic                                  BPRecoverEN,
  output logic [$clog2(PHYS_REGS-ARCH_COUNT+1)-1:0] free_count,
  output logic                                  overflow_err
);

  localparam int PRW   = (PHYS_REGS <= 2) ? 1 : $clog2(PHYS_REGS);
  localparam int DEPTH = PHYS_REGS - ARCH_COUNT;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int PW    = (DEPTH <= 2) ? 1 : $clog2(DEPTH);

  logic [PRW-1:0] fl [DEPTH];
  logic [PW-1:0]  head;
  logic [PW-1:0]  tail;
  logic [CW-1:0]  count;

  logic [CW-1:0]  req_total;
  logic [PW-1:0]  rd_idx [N];
  logic           push [N];
  logic [PW-1:0]  wr_idx [N];
  logic [CW-1:0]  push_total;
  logic           drop;
  logic [PW-1:0]  head_next;
  logic [PW-1:0]  tail_next;
  logic [CW-1:0]  count_next;

  function automatic logic [PW-1:0] wrap(input int v);
    return PW'(v % DEPTH);
  endfunction

  // Oldest lane (N-1) takes the tag at head; each requester shifts the
  // next lane's read slot by one.
  always_comb begin
    req_total = '0;
    for (int k = N - 1; k >= 0; k--) begin
      rd_idx[k] = wrap(int'(head) + int'(req_total));
      alloc_pr[k*PRW +: PRW] = fl[rd_idx[k]];
      if (alloc_req[k]) req_total = req_total + 1'b1;
    end
    alloc_ok = (req_total <= count);
  end

  // Running occupancy decides which frees fit; allocation this cycle
  // makes room first unless recovery discards it.
  always_comb begin
    int c;
    c = int'(count);
    if (!BPRecoverEN && alloc_ok) c = c - int'(req_total);
    push_total = '0;
    drop = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      push[k] = 1'b0;
      wr_idx[k] = wrap(int'(tail) + int'(push_total));
      if (free_en[k] && free_pr[k*PRW +: PRW] != '0) begin
        if (c < DEPTH) begin
          push[k] = 1'b1;
          push_total = push_total + 1'b1;
          c = c + 1;
        end else begin
          drop = 1'b1;
        end
      end
    end
  end

  always_comb begin
    tail_next = wrap(int'(tail) + int'(push_total));
    head_next = head;
    count_next = count + push_total;
    if (alloc_ok) begin
      head_next = wrap(int'(head) + int'(req_total));
      count_next = count - req_total + push_total;
    end
    // Everything between tail and head is in flight; collapsing the gap
    // returns it all without touching fl.
    if (BPRecoverEN) begin
      head_next = tail_next;
      count_next = CW'(DEPTH);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) fl[i] <= PRW'(ARCH_COUNT + i);
      head <= '0;
      tail <= '0;
      count <= CW'(DEPTH);
      overflow_err <= 1'b0;
    end else begin
      for (int k = 0; k < N; k++)
        if (push[k]) fl[wr_idx[k]] <= free_pr[k*PRW +: PRW];
      head <= head_next;
      tail <= tail_next;
      count <= count_next;
      if (drop) overflow_err <= 1'b1;
    end
  end

  assign free_count = count;

`ifndef SYNTHESIS
  always @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < N; k++)
        if (push[k])
          for (int i = 0; i < DEPTH; i++)
            if (i < int'(count))
              assert (fl[wrap(int'(head) + i)] != free_pr[k*PRW +: PRW])
                else $error("free_list: tag %0d freed twice",
                            free_pr[k*PRW +: PRW]);
      if (alloc_ok)
        for (int a = 0; a < N; a++)
          for (int b = a + 1; b < N; b++)
            if (alloc_req[a] && alloc_req[b])
              assert (alloc_pr[a*PRW +: PRW] != alloc_pr[b*PRW +: PRW])
                else $error("free_list: lanes %0d/%0d share a tag", a, b);
    end
  end
`endif

endmodule

// File: doc/free_list.md
Name: free_list

Overview:
- Circular free list of physical register tags, sitting directly upstream of the rename map table.
- Supplies up to N new physical tags per cycle for dispatch renames; these drive the map table's new-PR inputs.
- Reclaims the old physical mapping (Told) of each retiring instruction.
- On branch-mispredict recovery, restores in one cycle to "every non-architectural register is free".

Parameters:
- ARCH_COUNT, 32, number of architectural registers.
- PHYS_REGS, 64, number of physical registers.
- N, 3, superscalar width; lane N-1 is oldest, lane 0 youngest.
- PRW, (PHYS_REGS<=2)?1:$clog2(PHYS_REGS), localparam, physical tag width.
- DEPTH, PHYS_REGS-ARCH_COUNT, localparam, free list capacity.
- CW, $clog2(DEPTH+1), localparam, count width.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- alloc_req  in  N  per-lane request for a new physical tag (lane has a destination other than x0).
- alloc_pr  out  N*PRW  tag granted to each lane.
- alloc_ok  out  1  all requested lanes can be granted this cycle.
- free_en  in  N  per-lane retire frees a Told.
- free_pr  in  N*PRW  Told tag per lane.
- BPRecoverEN  in  1  mispredict recovery; restore the free list.
- free_count  out  CW  registered number of free entries.
- overflow_err  out  1  sticky flag: a free was dropped because the list was full.

Behaviour:
- Storage:
  - fl[DEPTH] of PRW-bit tags.
  - head pointer (pop) and tail pointer (push), each range 0..DEPTH-1, wrapping modulo DEPTH.
  - count register, 0..DEPTH.
- Async reset:
  - fl[i] = ARCH_COUNT+i; head = 0; tail = 0; count = DEPTH; overflow_err = 0.
  - P0..P(ARCH_COUNT-1) are the identity architectural mappings and are not free.
- Allocation (combinational from registered state, zero latency):
  - req_total = popcount(alloc_req).
  - For each lane k, processed oldest-first: off_k = number of requesting lanes older than k; alloc_pr[k] = fl[(head+off_k) mod DEPTH].
  - Non-requesting lanes output fl[(head+off_k) mod DEPTH] as don't-care, with no consumption.
  - alloc_ok = (req_total <= count). Frees in the same cycle are not visible to allocation.
  - If alloc_ok, the next edge sets head += req_total. If !alloc_ok, nothing is consumed (all-or-nothing) and dispatch stalls.
- Free (applied at the clock edge):
  - Lanes are pushed oldest-first at tail, tail+1, and so on.
  - A lane with free_pr == 0 is ignored; P0 is permanently mapped to x0 and is never freed.
  - A push that would make count exceed DEPTH is dropped and sets overflow_err; the flag is cleared only by reset.
- count_next = count - (alloc_ok ? req_total : 0) + accepted_frees.
  - Simultaneous allocation and free in one cycle is legal.
  - Allocation and free both reaching the wrap boundary in the same cycle must wrap correctly.
- Recovery (BPRecoverEN=1 at the edge):
  - That cycle's frees are applied first (tail advances).
  - Then head = tail_next and count = DEPTH. That cycle's allocation is discarded.
  - The region previously between tail and head holds exactly the in-flight speculative tags, so they return to the free list without any rewrite of fl.
- free_count is count, registered. Its reset value is DEPTH.
- Priority at the edge: reset > BPRecoverEN > normal update.
- Assertions (simulation only):
  - A freed tag is not already present in the free region.
  - alloc_pr for requesting lanes are pairwise distinct.

Test Plan:
- Reset, then alloc_req=3'b111 → alloc_pr = {32,33,34} for lanes {2,1,0}, alloc_ok=1; next cycle free_count=29.
- alloc_req=3'b101 with head=0 → lane2=32, lane0=33; head advances by 2; lane1 consumes nothing.
- Drain until count=2, then alloc_req=3'b111 → alloc_ok=0; head, count and free_count are unchanged next cycle.
- Allocate 10 tags, retire 4 with free_pr={5,6,7,0} → 3 pushed (P0 ignored), count=25; then BPRecoverEN=1 → count=32; next alloc_req=3'b100 returns the tag at the new head, which equals the oldest in-flight allocated tag.
- Wrap case: head=tail=30 with count at an appropriate level; alloc 3 and free 3 in one cycle → pointers become 1 mod 32 and count is unchanged.
- At count=32, free_en=3'b001 with free_pr=40 → push dropped, overflow_err=1 and stays 1; assert reset mid-run → all state returns to reset values immediately, without waiting for a clock edge.
